mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_pkg.sv | 17 +
 rtl/mem_arb_wdog.sv | 32 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the arbiter's WAIT states: counts wait cycles, fires expire on the
// TIMEOUT-th cycle without mem_ready and raises a sticky err flag.
module mem_arb_wdog import mips_pkg::*; #(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  output logic expire,
  output logic err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of wait cycles already spent, so cycle TIMEOUT sees TIMEOUT-1.
  assign expire = busy && !ready && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (busy && !ready && !expire) cnt <= cnt + 1'b1;
      else                           cnt <= '0;
      if (expire) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (if_*) and data (dm_*) requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter import mips_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  arb_state_t state, state_next;
  grant_t     last_grant;
  logic       wait_st;
  logic       grant_dm;
  logic       expire;
  logic       finish;

  assign wait_st = (state != IDLE);

  // dm wins a tie unless it also won the previous grant.
  assign grant_dm = dm_req && (!if_req || last_grant == GNT_IF);

  // A synchronous reset in the same cycle abandons the transaction silently.
  assign finish = wait_st && !rst && (mem_ready || expire);

`ifdef ARB_TIMEOUT_EN
  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (wait_st),
    .ready  (mem_ready),
    .expire (expire),
    .err    (err)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_dm)    state_next = DM_WAIT;
        else if (if_req) state_next = IF_WAIT;
      end
      IF_WAIT, DM_WAIT: begin
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The granted requester's fields are captured on the way out of IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_IF;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else if (state == IDLE) begin
      if (grant_dm) begin
        last_grant <= GNT_DM;
        mem_we     <= dm_we;
        mem_addr   <= dm_addr;
        mem_wdata  <= dm_wdata;
        mem_be     <= dm_be;
      end else if (if_req) begin
        last_grant <= GNT_IF;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        mem_be     <= '1;
      end
    end
  end

  // done is suppressed if the owner dropped its request mid-transaction.
  always_comb begin
    if_done  = 1'b0;
    dm_done  = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    mem_req  = wait_st;
    if (finish && state == IF_WAIT) if_done = if_req;
    if (finish && state == DM_WAIT) dm_done = dm_req;
    if (if_done && mem_ready)            if_rdata = mem_rdata;
    if (dm_done && mem_ready && !mem_we) dm_rdata = mem_rdata;
  end

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dm_req & ~dm_done;

endmodule
